secded_decoder_pipe: RTL and testbench

Parametrised, pipelined SECDED (Hamming + overall parity) decoder. It accepts a data word, its Hamming parity bits and the overall DED parity bit, and classifies the word as clean, single-error or double-error. Single errors are corrected, and the bit position is reported. The block sits on the memory/register read return path, replacing the separate combinational SEC and DED checks. It adds valid/ready flow control and saturating error-event counters for scrub and health monitoring.

---
 rtl/secded_decoder_pipe.sv | 174 +++++++++++++++++
 tb/tb_secded_decoder_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage pipelined SECDED decoder (Hamming + overall parity)
// with valid/ready flow control and saturating single/double error counters.
module secded_decoder_pipe #(
   parameter int DATA_W = 32,
   parameter int PAR_W  = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PAR_W-1:0]  in_parity,
   input  logic              in_parity_ded,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_single_err,
   output logic              out_double_err,
   output logic [PAR_W-1:0]  out_err_pos,
   input  logic              clr_counts,
   output logic [CNT_W-1:0]  sec_count,
   output logic [CNT_W-1:0]  ded_count
);

   localparam int               N_POS   = DATA_W + PAR_W;
   localparam logic [PAR_W-1:0] N_POS_V = PAR_W'(N_POS);

   // Codeword position of data bit k: the k-th non-power-of-two position from 3 upward.
   function automatic logic [PAR_W-1:0] data_pos(input int k);
      int               cnt;
      logic [PAR_W-1:0] res;
      cnt = 32'sd0;
      res = {PAR_W{1'b0}};
      for (int p = 32'sd3; p <= N_POS; p++) begin
         if ((p & (p - 32'sd1)) != 32'sd0) begin
            if (cnt == k) begin
               res = PAR_W'(p);
            end
            cnt++;
         end
      end
      return res;
   endfunction

   function automatic logic overall_mismatch(input logic [DATA_W-1:0] d,
                                             input logic [PAR_W-1:0]  p,
                                             input logic              e);
      return (^d) ^ (^p) ^ e;
   endfunction

   logic [PAR_W-1:0] pos_tab [DATA_W];

   for (genvar g = 0; g < DATA_W; g++) begin : g_pos_tab
      assign pos_tab[g] = data_pos(g);
   end

   function automatic logic [PAR_W-1:0] syndrome(input logic [DATA_W-1:0] d,
                                                 input logic [PAR_W-1:0]  p);
      logic [PAR_W-1:0] s;
      s = p;
      for (int k = 32'sd0; k < DATA_W; k++) begin
         s = s ^ (pos_tab[k] & {PAR_W{d[k]}});
      end
      return s;
   endfunction

   logic              stall_s;
   logic              s1_valid_r;
   logic [DATA_W-1:0] s1_data_r;
   logic [PAR_W-1:0]  s1_syn_r;
   logic              s1_ovr_r;
   logic [DATA_W-1:0] fix_data_s;
   logic              fix_single_s;
   logic              fix_double_s;
   logic [PAR_W-1:0]  fix_pos_s;

   // Both stages freeze together whenever the result register is held by the consumer.
   assign stall_s  = out_valid & ~out_ready;
   assign in_ready = ~stall_s;

   // Stage 1: register received data with its syndrome and overall mismatch
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {DATA_W{1'b0}};
         s1_syn_r   <= {PAR_W{1'b0}};
         s1_ovr_r   <= 1'b0;
      end else if (!stall_s) begin
         s1_valid_r <= in_valid;
         s1_data_r  <= in_data;
         s1_syn_r   <= syndrome(in_data, in_parity);
         s1_ovr_r   <= overall_mismatch(in_data, in_parity, in_parity_ded);
      end
   end

   // Classify the stage-1 word and correct a single flipped data bit
   always_comb begin
      fix_data_s   = s1_data_r;
      fix_single_s = 1'b0;
      fix_double_s = 1'b0;
      fix_pos_s    = {PAR_W{1'b0}};
      if (s1_valid_r) begin
         case ({|s1_syn_r, s1_ovr_r})
            2'b00: begin
               fix_single_s = 1'b0;
            end
            2'b01: begin
               fix_single_s = 1'b1;
            end
            2'b10: begin
               fix_double_s = 1'b1;
            end
            2'b11: begin
               // A syndrome beyond the last codeword position cannot be a single flip.
               if (s1_syn_r <= N_POS_V) begin
                  fix_single_s = 1'b1;
                  fix_pos_s    = s1_syn_r;
                  for (int k = 32'sd0; k < DATA_W; k++) begin
                     if (pos_tab[k] == s1_syn_r) begin
                        fix_data_s[k] = ~s1_data_r[k];
                     end else begin
                        fix_data_s[k] = s1_data_r[k];
                     end
                  end
               end else begin
                  fix_double_s = 1'b1;
               end
            end
            default: begin
               fix_double_s = 1'b1;
            end
         endcase
      end else begin
         fix_single_s = 1'b0;
      end
   end

   // Stage 2: register corrected data and error classification
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_data       <= {DATA_W{1'b0}};
         out_single_err <= 1'b0;
         out_double_err <= 1'b0;
         out_err_pos    <= {PAR_W{1'b0}};
      end else if (!stall_s) begin
         out_valid      <= s1_valid_r;
         out_data       <= fix_data_s;
         out_single_err <= fix_single_s;
         out_double_err <= fix_double_s;
         out_err_pos    <= fix_pos_s;
      end
   end

   // Saturating event counters, advanced only when a flagged result is handed off
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_count <= {CNT_W{1'b0}};
         ded_count <= {CNT_W{1'b0}};
      end else if (clr_counts) begin
         sec_count <= {CNT_W{1'b0}};
         ded_count <= {CNT_W{1'b0}};
      end else begin
         if (out_valid && out_ready && out_single_err && (sec_count != {CNT_W{1'b1}})) begin
            sec_count <= sec_count + CNT_W'(1'b1);
         end
         if (out_valid && out_ready && out_double_err && (ded_count != {CNT_W{1'b1}})) begin
            ded_count <= ded_count + CNT_W'(1'b1);
         end
      end
   end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench for secded_decoder_pipe (CNT_W=2 so saturation is reachable quickly).
module tb_secded_decoder_pipe;

   localparam int DATA_W = 32;
   localparam int PAR_W  = 6;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [PAR_W-1:0]  in_parity;
   logic              in_parity_ded;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_single_err;
   logic              out_double_err;
   logic [PAR_W-1:0]  out_err_pos;
   logic              clr_counts;
   logic [CNT_W-1:0]  sec_count;
   logic [CNT_W-1:0]  ded_count;

   int total = 0;
   int bad   = 0;

   secded_decoder_pipe #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_parity(in_parity), .in_parity_ded(in_parity_ded),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_single_err(out_single_err), .out_double_err(out_double_err),
      .out_err_pos(out_err_pos), .clr_counts(clr_counts),
      .sec_count(sec_count), .ded_count(ded_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_one(input logic [31:0] d, input logic [5:0] p, input logic e);
      in_data = d; in_parity = p; in_parity_ded = e;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic chk_out(input string tag, input logic [31:0] d, input logic s,
                          input logic dd, input logic [5:0] pos);
      chk({tag, "_valid"},  out_valid, 1'b1);
      chk({tag, "_data"},   out_data, d);
      chk({tag, "_single"}, out_single_err, s);
      chk({tag, "_double"}, out_double_err, dd);
      chk({tag, "_pos"},    out_err_pos, pos);
   endtask

   // Clean codewords for the backpressure stream (data bits 0..3 sit at positions 3,5,6,7).
   logic [31:0] bp_d [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h3};
   logic [5:0]  bp_p [5] = '{6'b000011, 6'b000101, 6'b000110, 6'b000111, 6'b000110};
   logic        bp_e [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      int          tx;
      int          rx;
      logic        stalled;
      logic        acc;
      logic [31:0] held;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_counts = 1'b0;
      in_data = 32'h0; in_parity = 6'h0; in_parity_ded = 1'b0;
      tick(); tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_flags", {out_single_err, out_double_err}, 2'b00);
      chk("rst_pos", out_err_pos, 6'h0);
      chk("rst_counts", {sec_count, ded_count}, 4'h0);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1'b1);

      send_one(32'h1, 6'b000011, 1'b1);
      chk_out("clean", 32'h1, 1'b0, 1'b0, 6'd0);
      tick();
      chk("clean_sec", sec_count, 2'd0);

      send_one(32'h0, 6'b000011, 1'b1);
      chk_out("sec_data", 32'h1, 1'b1, 1'b0, 6'd3);
      tick();
      chk("sec_data_cnt", sec_count, 2'd1);

      send_one(32'h0, 6'b000000, 1'b1);
      chk_out("ded_bit", 32'h0, 1'b1, 1'b0, 6'd0);
      tick();
      chk("ded_bit_cnt", sec_count, 2'd2);

      // syn=3, ovr=0: two flips
      send_one(32'h1, 6'b000000, 1'b1);
      chk_out("double", 32'h1, 1'b0, 1'b1, 6'd0);
      tick();
      chk("double_cnt", ded_count, 2'd1);

      // syn=47 > 38 with ovr=1
      send_one(32'h8, 6'b101000, 1'b0);
      chk_out("oor", 32'h8, 1'b0, 1'b1, 6'd0);
      tick();
      chk("oor_cnt", ded_count, 2'd2);

      send_one(32'h0, 6'b000001, 1'b0);
      chk_out("par_pos", 32'h0, 1'b1, 1'b0, 6'd1);
      tick();
      chk("par_pos_cnt", sec_count, 2'd3);

      // data[31] lives at the last position, 38
      send_one(32'h8000_0000, 6'b000000, 1'b0);
      chk_out("last_pos", 32'h0, 1'b1, 1'b0, 6'd38);
      tick();
      chk("sec_saturate", sec_count, 2'd3);
      chk("drained_valid", out_valid, 1'b0);

      clr_counts = 1'b1;
      tick();
      clr_counts = 1'b0;
      chk("clr_counts", {sec_count, ded_count}, 4'h0);

      send_one(32'h0, 6'b000011, 1'b1);
      clr_counts = 1'b1;
      tick();
      clr_counts = 1'b0;
      chk("clr_priority", sec_count, 2'd0);

      in_data = 32'h0; in_parity = 6'b000011; in_parity_ded = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("stream_saturate", sec_count, 2'd3);
      chk("stream_ded", ded_count, 2'd0);

      tx = 0; rx = 0;
      for (int cyc = 0; cyc < 60 && rx < 5; cyc++) begin
         in_valid      = (tx < 5);
         in_data       = (tx < 5) ? bp_d[tx] : 32'h0;
         in_parity     = (tx < 5) ? bp_p[tx] : 6'h0;
         in_parity_ded = (tx < 5) ? bp_e[tx] : 1'b0;
         out_ready     = ((cyc % 3) == 0);
         #1;
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (stalled) chk("bp_in_ready", in_ready, 1'b0);
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            chk("bp_order", out_data, bp_d[rx]);
            chk("bp_flags", {out_single_err, out_double_err}, 2'b00);
            rx++;
         end
         tick();
         if (stalled) chk("bp_hold", {out_valid, out_data}, {1'b1, held});
         if (acc) tx++;
      end
      chk("bp_delivered", rx, 5);
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();

      in_data = 32'h0; in_parity = 6'b000011; in_parity_ded = 1'b1;
      in_valid = 1'b1;
      tick(); tick();
      chk("mid_pre_valid", out_valid, 1'b1);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_out", {out_data, out_single_err, out_double_err, out_err_pos}, 40'h0);
      chk("mid_rst_counts", {sec_count, ded_count}, 4'h0);
      rst = 1'b0;
      tick();
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_flush", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
